counter_down: RTL and testbench

Loadable down-counter (countdown timer) with a completion handshake. It is the consumer-side complement of the team's up-counter: a value is loaded, decremented on each enabled cycle, and done is raised at zero. Done is held until the requester acknowledges it. Intended as a timeout/delay block next to the up-counter in the same clock domain.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_down.sv | 97 +++++++++
 tb/tb_counter_down.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_pkg: state encoding and default width shared by the counters.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package counter_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_down.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | counter_down: loadable countdown timer with done/ack handshake.          |
// | Optional feature macro: COUNTER_DOWN_AUTORELOAD_EN (wrap to loaded value)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module counter_down
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             dec,
  input  logic             ack,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;

`ifdef COUNTER_DOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
  logic             wrap;
  logic             wrap_pulse;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

`ifdef COUNTER_DOWN_AUTORELOAD_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reload     <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= wrap;
      if (load) reload <= in;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = count;
`ifdef COUNTER_DOWN_AUTORELOAD_EN
    wrap      = 1'b0;
`endif
    // Load has priority over dec in every state and over ack in DONE.
    if (load) begin
      count_nxt = in;
      state_nxt = (in == '0) ? DONE : RUN;
    end else begin
      case (state)
        RUN: begin
          if (dec) begin
            if (count == WIDTH'(1)) begin
`ifdef COUNTER_DOWN_AUTORELOAD_EN
              count_nxt = reload;
              wrap      = 1'b1;
`else
              count_nxt = '0;
              state_nxt = DONE;
`endif
            end else begin
              count_nxt = count - WIDTH'(1);
            end
          end
        end
        DONE:    if (ack) state_nxt = IDLE;
        IDLE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign value = count;
  assign busy  = (state == RUN);
`ifdef COUNTER_DOWN_AUTORELOAD_EN
  assign done  = (state == DONE) | wrap_pulse;
`else
  assign done  = (state == DONE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_down.sv
`default_nettype none
// Self-checking bench for counter_down: directed vector table, reset
// sequence, then randomized traffic against a behavioural model.
module tb_counter_down;

  localparam int W = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din   = '0;
  logic         load  = 1'b0;
  logic         dec   = 1'b0;
  logic         ack   = 1'b0;
  logic [W-1:0] value;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  counter_down #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .in(din), .load(load), .dec(dec),
    .ack(ack), .value(value), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Behavioural model: mode 0=idle, 1=counting, 2=expired.
  int m_mode = 0, m_val = 0, m_reload = 0;
  bit m_pulse = 0;

  function automatic void model_reset();
    m_mode = 0; m_val = 0; m_reload = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(int ld, int d, int dc, int ak);
    m_pulse = 0;
    if (ld != 0) begin
      m_val = d; m_reload = d;
      m_mode = (d == 0) ? 2 : 1;
    end else if (m_mode == 1 && dc != 0) begin
      if (m_val - 1 == 0) begin
`ifdef COUNTER_DOWN_AUTORELOAD_EN
        m_val = m_reload; m_pulse = 1;
`else
        m_val = 0; m_mode = 2;
`endif
      end else m_val = m_val - 1;
    end else if (m_mode == 2 && ak != 0) m_mode = 0;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(int ld, int d, int dc, int ak);
    @(negedge clock);
    load = ld[0]; din = W'(d); dec = dc[0]; ack = ak[0];
    @(posedge clock);
    model_step(ld, d, dc, ak);
    #1;
  endtask

  task automatic check_model(string tag);
    check({tag, ".value"}, int'(value), m_val);
    check({tag, ".busy"},  int'(busy),  (m_mode == 1) ? 1 : 0);
    check({tag, ".done"},  int'(done),  (m_mode == 2 || m_pulse) ? 1 : 0);
  endtask

  typedef struct {
    int ld; int d; int dc; int ak;
    int ev; int eb; int ed;
  } vec_t;

`ifdef COUNTER_DOWN_AUTORELOAD_EN
  localparam int NV = 9;
  vec_t tbl [NV] = '{
    '{1,2,0,0, 2,1,0}, '{0,0,1,0, 1,1,0}, '{0,0,1,0, 2,1,1},
    '{0,0,1,0, 1,1,0}, '{0,0,1,0, 2,1,1}, '{0,0,0,0, 2,1,0},
    '{0,0,0,1, 2,1,0}, '{1,0,0,0, 0,0,1}, '{0,0,0,1, 0,0,0}
  };
`else
  localparam int NV = 28;
  vec_t tbl [NV] = '{
    '{1,5,0,0, 5,1,0}, '{0,0,1,0, 4,1,0}, '{0,0,1,0, 3,1,0},
    '{0,0,1,0, 2,1,0}, '{0,0,1,0, 1,1,0}, '{0,0,1,0, 0,0,1},
    '{0,0,1,0, 0,0,1}, '{0,0,0,1, 0,0,0}, '{0,0,1,1, 0,0,0},
    '{1,0,0,0, 0,0,1}, '{0,0,0,1, 0,0,0}, '{1,3,0,0, 3,1,0},
    '{0,0,1,0, 2,1,0}, '{0,0,0,0, 2,1,0}, '{0,0,1,0, 1,1,0},
    '{0,0,0,1, 1,1,0}, '{0,0,1,0, 0,0,1}, '{1,5,0,0, 5,1,0},
    '{0,0,1,0, 4,1,0}, '{0,0,1,0, 3,1,0}, '{0,0,1,0, 2,1,0},
    '{1,7,1,0, 7,1,0}, '{1,1,0,0, 1,1,0}, '{0,0,1,0, 0,0,1},
    '{1,2,0,1, 2,1,0}, '{0,0,1,0, 1,1,0}, '{0,0,1,0, 0,0,1},
    '{0,0,0,1, 0,0,0}
  };
`endif

  initial begin
    model_reset();
    #12;
    check("rst.value", int'(value), 0);
    check("rst.busy",  int'(busy),  0);
    check("rst.done",  int'(done),  0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].ld, tbl[i].d, tbl[i].dc, tbl[i].ak);
      check($sformatf("vec%0d.value", i), int'(value), tbl[i].ev);
      check($sformatf("vec%0d.busy",  i), int'(busy),  tbl[i].eb);
      check($sformatf("vec%0d.done",  i), int'(done),  tbl[i].ed);
    end

    // Asynchronous reset in the middle of a count, between clock edges.
    apply(1, 6, 0, 0);
    apply(0, 0, 1, 0);
    apply(0, 0, 1, 0);
    check("pre_rst.value", int'(value), 4);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_rst.value", int'(value), 0);
    check("async_rst.busy",  int'(busy),  0);
    check("async_rst.done",  int'(done),  0);
    @(negedge clock);
    reset = 1'b1;
    apply(0, 0, 1, 1);
    check_model("post_rst");
    check("post_rst.idle_value", int'(value), 0);

    for (int i = 0; i < 500; i++) begin
      apply(($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
